// File: rtl/sticky_ff_bank.sv
// Bank of N sticky/plain flags with a first-set index capture
// and a saturating count of cycles in which any flag newly rises.
module sticky_ff_bank #(
    parameter int N    = 8,
    parameter int CW   = 4,
    parameter int MODE = 1
) (
    input  logic                 CK,
    input  logic                 RSTN,
    input  logic [N-1:0]         D,
    input  logic [N-1:0]         CLR,
    input  logic                 CNT_CLR,
    output logic [N-1:0]         Q,
    output logic                 ANY,
    output logic [$clog2(N)-1:0] FIRST,
    output logic                 FIRST_VLD,
    output logic [CW-1:0]        CNT
);

    localparam int FW = $clog2(N);
    localparam logic [CW-1:0] CMAX = '1;

    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  dd_q, dd_d;
    logic [FW-1:0] first_q, first_d;
    logic          vld_q, vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  set_v;
    logic [N-1:0]  ns;
    logic [FW-1:0] low;

    always_comb begin
        dd_d  = '0;
        set_v = D;
        q_d   = D;
        if (MODE == 2) begin
            dd_d  = D;
            set_v = D & ~dd_q;
        end
        if (MODE != 0) begin
            // Set wins over a same-cycle clear.
            q_d = set_v | (q_q & ~CLR);
        end
        ns = ~q_q & q_d;
    end

    always_comb begin
        low = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ns[i]) begin
                low = FW'(i);
            end
        end
    end

    always_comb begin
        first_d = first_q;
        vld_d   = vld_q;
        if (q_d == '0) begin
            first_d = '0;
            vld_d   = 1'b0;
        end else if (!vld_q && ns != '0) begin
            first_d = low;
            vld_d   = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (CNT_CLR) begin
            // Keep an event that lands on the clearing cycle.
            cnt_d = (ns != '0) ? CW'(1) : '0;
        end else if (ns != '0 && cnt_q != CMAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            q_q     <= '0;
            dd_q    <= '0;
            first_q <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            q_q     <= q_d;
            dd_q    <= dd_d;
            first_q <= first_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Q         = q_q;
    assign ANY       = |q_q;
    assign FIRST     = first_q;
    assign FIRST_VLD = vld_q;
    assign CNT       = cnt_q;

endmodule

// File: tb/tb_sticky_ff_bank.sv
// Directed vector bench for sticky_ff_bank in all three modes.
module tb_sticky_ff_bank;

    typedef struct {
        string      nm;
        logic       rstn;
        logic [7:0] d;
        logic [7:0] clr;
        logic       cc;
        logic [7:0] q;
        logic       any;
        logic [2:0] f;
        logic       v;
        logic [3:0] c;
    } vec_t;

    logic       CK = 1'b0;
    logic       rstn [3];
    logic [7:0] d    [3];
    logic [7:0] clr  [3];
    logic       cc   [3];
    logic [7:0] q    [3];
    logic       any  [3];
    logic [2:0] f    [3];
    logic       v    [3];
    logic [3:0] c    [3];

    int nvec = 0;
    int nerr = 0;

    always #5 CK = ~CK;

    sticky_ff_bank #(.N(8), .CW(4), .MODE(0)) u_m0 (
        .CK(CK), .RSTN(rstn[0]), .D(d[0]), .CLR(clr[0]),
        .CNT_CLR(cc[0]), .Q(q[0]), .ANY(any[0]), .FIRST(f[0]),
        .FIRST_VLD(v[0]), .CNT(c[0])
    );
    sticky_ff_bank #(.N(8), .CW(4), .MODE(1)) u_m1 (
        .CK(CK), .RSTN(rstn[1]), .D(d[1]), .CLR(clr[1]),
        .CNT_CLR(cc[1]), .Q(q[1]), .ANY(any[1]), .FIRST(f[1]),
        .FIRST_VLD(v[1]), .CNT(c[1])
    );
    sticky_ff_bank #(.N(8), .CW(4), .MODE(2)) u_m2 (
        .CK(CK), .RSTN(rstn[2]), .D(d[2]), .CLR(clr[2]),
        .CNT_CLR(cc[2]), .Q(q[2]), .ANY(any[2]), .FIRST(f[2]),
        .FIRST_VLD(v[2]), .CNT(c[2])
    );

    function automatic vec_t mk(
        input string nm, input logic r, input logic [7:0] dd,
        input logic [7:0] cl, input logic ccl, input logic [7:0] eq,
        input logic ea, input logic [2:0] ef, input logic ev,
        input logic [3:0] ec
    );
        vec_t t;
        t.nm = nm; t.rstn = r; t.d = dd; t.clr = cl; t.cc = ccl;
        t.q = eq; t.any = ea; t.f = ef; t.v = ev; t.c = ec;
        return t;
    endfunction

    task automatic run(input int m, input vec_t t);
        @(negedge CK);
        rstn[m] = t.rstn;
        d[m]    = t.d;
        clr[m]  = t.clr;
        cc[m]   = t.cc;
        @(posedge CK);
        #1;
        nvec++;
        if (q[m] !== t.q || any[m] !== t.any || f[m] !== t.f ||
            v[m] !== t.v || c[m] !== t.c) begin
            nerr++;
            $display("FAIL m%0d %s: got Q=%h ANY=%b FIRST=%0d VLD=%b CNT=%0d, want Q=%h ANY=%b FIRST=%0d VLD=%b CNT=%0d",
                     m, t.nm, q[m], any[m], f[m], v[m], c[m],
                     t.q, t.any, t.f, t.v, t.c);
        end
    endtask

    vec_t tv[$];

    initial begin
        for (int m = 0; m < 3; m++) begin
            rstn[m] = 1'b0; d[m] = '0; clr[m] = '0; cc[m] = 1'b0;
        end

        // MODE 1 table
        tv.push_back(mk("rst",      0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tv.push_back(mk("set2",     1, 8'h04, 8'h00, 0, 8'h04, 1, 2, 1, 1));
        tv.push_back(mk("hold2a",   1, 8'h00, 8'h00, 0, 8'h04, 1, 2, 1, 1));
        tv.push_back(mk("hold2b",   1, 8'h00, 8'h00, 0, 8'h04, 1, 2, 1, 1));
        tv.push_back(mk("clr2",     1, 8'h00, 8'h04, 0, 8'h00, 0, 0, 0, 1));
        tv.push_back(mk("set28",    1, 8'h28, 8'h00, 0, 8'h28, 1, 3, 1, 2));
        tv.push_back(mk("set01",    1, 8'h01, 8'h00, 0, 8'h29, 1, 3, 1, 3));
        tv.push_back(mk("reset01",  1, 8'h01, 8'h00, 0, 8'h29, 1, 3, 1, 3));
        tv.push_back(mk("clrall",   1, 8'h00, 8'hff, 0, 8'h00, 0, 0, 0, 3));
        tv.push_back(mk("set05",    1, 8'h05, 8'h00, 0, 8'h05, 1, 0, 1, 4));
        tv.push_back(mk("collide",  1, 8'h01, 8'h05, 0, 8'h01, 1, 0, 1, 4));
        tv.push_back(mk("clr01",    1, 8'h00, 8'h01, 0, 8'h00, 0, 0, 0, 4));
        tv.push_back(mk("cntclr",   1, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0));
        tv.push_back(mk("set03",    1, 8'h03, 8'h00, 0, 8'h03, 1, 0, 1, 1));
        tv.push_back(mk("midrst",   0, 8'hff, 8'h00, 1, 8'h00, 0, 0, 0, 0));
        tv.push_back(mk("postrst",  1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        foreach (tv[i]) run(1, tv[i]);

        // MODE 1 saturation, then clear colliding with a new set
        run(1, mk("sat_rst", 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            logic [3:0] e;
            e = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            run(1, mk("sat_set", 1, 8'h01, 8'h00, 0, 8'h01, 1, 0, 1, e));
            run(1, mk("sat_clr", 1, 8'h00, 8'h01, 0, 8'h00, 0, 0, 0, e));
        end
        run(1, mk("cc_set", 1, 8'h02, 8'h00, 1, 8'h02, 1, 1, 1, 1));

        // MODE 2: D held through reset release is one rising edge
        run(2, mk("m2_rst", 0, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        run(2, mk("m2_rise", 1, 8'h01, 8'h00, 0, 8'h01, 1, 0, 1, 1));
        for (int i = 0; i < 4; i++)
            run(2, mk("m2_held", 1, 8'h01, 8'h00, 0, 8'h01, 1, 0, 1, 1));
        run(2, mk("m2_clr",  1, 8'h01, 8'h01, 0, 8'h00, 0, 0, 0, 1));
        run(2, mk("m2_hi",   1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0, 1));
        run(2, mk("m2_fall", 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1));
        run(2, mk("m2_rise2", 1, 8'h01, 8'h00, 0, 8'h01, 1, 0, 1, 2));
        run(2, mk("m2_rise4", 1, 8'h11, 8'h00, 0, 8'h11, 1, 0, 1, 3));

        // MODE 0: plain flops, CLR ignored
        run(0, mk("m0_rst",  0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        run(0, mk("m0_0f",   1, 8'h0f, 8'h00, 0, 8'h0f, 1, 0, 1, 1));
        run(0, mk("m0_00",   1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1));
        run(0, mk("m0_clr",  1, 8'h0c, 8'h0c, 0, 8'h0c, 1, 2, 1, 2));
        run(0, mk("m0_mid",  0, 8'hff, 8'h00, 0, 8'h00, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sticky_ff_bank.md
STICKY_FF_BANK -- requirements
Module: sticky_ff_bank

Interface
REQ-001 SHALL have parameter N, default 8: channel count, 2..32.
REQ-002 SHALL have parameter CW, default 4: event-counter width, 2..16.
REQ-003 SHALL have parameter MODE, default 1: 0 = plain D flip-flop, 1 = sticky level-set, 2 = sticky rising-edge-set.
REQ-004 SHALL have port CK  input  1: single clock; all state updates on posedge CK.
REQ-005 SHALL have port RSTN  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port D  input  N: per-channel data/set request.
REQ-007 SHALL have port CLR  input  N: per-channel clear request, active-high.
REQ-008 SHALL have port CNT_CLR  input  1: event-counter clear, active-high.
REQ-009 SHALL have port Q  output  N: registered channel flags.
REQ-010 SHALL have port ANY  output  1: OR-reduction of Q, combinational from Q.
REQ-011 SHALL have port FIRST  output  clog2(N): index of first channel set since flags were last all-zero.
REQ-012 SHALL have port FIRST_VLD  output  1: FIRST holds a valid index.
REQ-013 SHALL have port CNT  output  CW: saturating count of set-event cycles.

Function
REQ-014 SHALL, for each channel, define the set condition per MODE: MODE 0/1 -> D[i]=1; MODE 2 -> D[i]=1 and the previous-cycle sample D_d[i]=0.
REQ-015 SHALL, in MODE 0, update Q[i] <= D[i] every cycle; CLR has no effect.
REQ-016 SHALL, in MODE 1/2, update Q[i] <= 1 on the set condition, else 0 if CLR[i]=1, else hold.
REQ-017 SHALL, when set and CLR hit the same channel in the same cycle, give priority to set; Q[i] ends at 1.
REQ-018 SHALL, in MODE 2, register D into D_d every cycle; D_d SHALL NOT be used in other modes.
REQ-019 SHALL define the newly-set vector NS[i] = ~Q[i] & Qnext[i].
REQ-020 SHALL, when FIRST_VLD=0 and NS!=0, load FIRST with the lowest i having NS[i]=1 and set FIRST_VLD=1, both visible in the same cycle Q rises.
REQ-021 SHALL, while FIRST_VLD=1, hold FIRST regardless of further sets.
REQ-022 SHALL, when Qnext==0, clear FIRST_VLD and FIRST to 0 in that same update.
REQ-023 SHALL increment CNT by exactly 1 in any cycle with NS!=0, regardless of how many bits are newly set.
REQ-024 SHALL saturate CNT at 2^CW-1; no wrap-around.
REQ-025 SHALL, on CNT_CLR=1, load CNT with 0, or with 1 if NS!=0 in the same cycle, so the event is not lost.
REQ-026 SHALL give all outputs a single-cycle latency from the input sample: D/CLR at edge k are reflected at edge k.

Reset
REQ-027 SHALL, on posedge CK with RSTN=0, set Q=0, D_d=0, FIRST=0, FIRST_VLD=0 and CNT=0; ANY then reads 0.
REQ-028 SHALL give RSTN=0 priority over D, CLR and CNT_CLR.
REQ-029 SHALL, in MODE 2, treat D=1 held through reset release as a rising edge on the first cycle after release, because D_d resets to 0.
REQ-030 SHALL, on reset asserted mid-operation, discard all flags and the count with no residual state.

Verification (N=8, CW=4, MODE=1 unless stated)
REQ-031 SHALL cover sticky set: D=0x04 for 1 cycle then 0 -> Q=0x04 holds, ANY=1, FIRST=2, FIRST_VLD=1, CNT=1.
REQ-032 SHALL cover first-index priority: from Q=0, D=0x28 in one cycle -> FIRST=3, CNT=1; then D=0x01 -> FIRST stays 3, CNT=2.
REQ-033 SHALL cover clear and set collision: Q=0x05, CLR=0x05 with D=0x01 -> Q=0x01, FIRST_VLD=1; then CLR=0x01 -> Q=0, FIRST_VLD=0.
REQ-034 SHALL cover saturation and counter clear: 20 separate set events -> CNT=15; CNT_CLR with a new set in the same cycle -> CNT=1.
REQ-035 SHALL cover MODE 2: D[0] held 1 for 5 cycles after reset release -> exactly one event, CNT=1; after CLR[0], no re-set until D[0] falls and rises again.
REQ-036 SHALL cover MODE 0 and reset: D pattern 0x0F,0x00 -> Q follows with 1-cycle latency, CNT=1; RSTN=0 mid-run -> all outputs 0 at the next edge.
